arp_packet_parser: RTL

Receive-side ARP parser on the GMII RX path. It hunts preamble/SFD, captures the Ethernet + ARP header fields, checks the IEEE 802.3 FCS and header constants, and pulses a one-cycle result whose sender MAC/IP and operator drive the ARP packet generator's `req` and address inputs. It sits directly upstream of the generator and forms the request/reply loop of the ARP responder.

---
 rtl/arp_packet_parser.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/arp_packet_parser.sv
// Receive-side ARP parser on GMII RX: preamble/SFD hunt, header capture, FCS and constant checks.
// Optional DA/TPA filtering is enabled by defining ARP_RX_FILTER_EN.
module arp_packet_parser #(
    parameter int MAX_FRAME = 1518
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        gmii_rx_dv,
    input  logic        gmii_rx_er,
    input  logic [7:0]  gmii_rxd,
    input  logic [47:0] local_mac_add,
    input  logic [31:0] local_ip_add,
    output logic        arp_valid,
    output logic [47:0] sender_mac_add,
    output logic [31:0] sender_ip_add,
    output logic [15:0] operator,
    output logic        frame_err
);

    typedef enum logic [2:0] {
        ST_SYNC     = 3'd0,
        ST_IDLE     = 3'd1,
        ST_PREAMBLE = 3'd2,
        ST_DATA     = 3'd3,
        ST_CHECK    = 3'd4,
        ST_DROP     = 3'd5
    } state_t;

    localparam logic [10:0] MAX_LEN   = 11'(MAX_FRAME);
    localparam logic [10:0] MIN_LEN   = 11'd64;
    localparam logic [10:0] HDR_BYTES = 11'd42;
    localparam logic [31:0] CRC_INIT  = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESID = 32'hDEBB_20E3;

    // Reflected CRC-32 (poly 0x04C11DB7), one byte, LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) begin
                c = (c >> 1) ^ 32'hEDB8_8320;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

    state_t      state_r;
    logic [10:0] count_r;
    logic [31:0] crc_r;
    logic        drop_from_data_r;
    logic [7:0]  hdr_r [0:41];

    logic [47:0] da_s;
    logic [15:0] ethertype_s;
    logic [15:0] htype_s;
    logic [15:0] ptype_s;
    logic [7:0]  hlen_s;
    logic [7:0]  plen_s;
    logic [15:0] oper_s;
    logic [47:0] sha_s;
    logic [31:0] spa_s;
    logic [31:0] tpa_s;
    logic        len_ok_s;
    logic        crc_ok_s;
    logic        hdr_ok_s;
    logic        oper_ok_s;
    logic        filter_ok_s;
    logic        frame_good_s;

    // Field extraction and frame acceptance from the captured header bytes.
    always_comb begin
        da_s        = {hdr_r[0], hdr_r[1], hdr_r[2], hdr_r[3], hdr_r[4], hdr_r[5]};
        ethertype_s = {hdr_r[12], hdr_r[13]};
        htype_s     = {hdr_r[14], hdr_r[15]};
        ptype_s     = {hdr_r[16], hdr_r[17]};
        hlen_s      = hdr_r[18];
        plen_s      = hdr_r[19];
        oper_s      = {hdr_r[20], hdr_r[21]};
        sha_s       = {hdr_r[22], hdr_r[23], hdr_r[24], hdr_r[25], hdr_r[26], hdr_r[27]};
        spa_s       = {hdr_r[28], hdr_r[29], hdr_r[30], hdr_r[31]};
        tpa_s       = {hdr_r[38], hdr_r[39], hdr_r[40], hdr_r[41]};
        len_ok_s    = (count_r >= MIN_LEN) && (count_r <= MAX_LEN);
        crc_ok_s    = (crc_r == CRC_RESID);
        hdr_ok_s    = (ethertype_s == 16'h0806) && (htype_s == 16'h0001) &&
                      (ptype_s == 16'h0800) && (hlen_s == 8'd6) && (plen_s == 8'd4);
        oper_ok_s   = (oper_s == 16'h0001) || (oper_s == 16'h0002);
`ifdef ARP_RX_FILTER_EN
        filter_ok_s = ((da_s == 48'hFFFF_FFFF_FFFF) || (da_s == local_mac_add)) &&
                      (tpa_s == local_ip_add);
`else
        filter_ok_s = 1'b1;
`endif
        frame_good_s = len_ok_s && crc_ok_s && hdr_ok_s && oper_ok_s && filter_ok_s;
    end

`ifndef ARP_RX_FILTER_EN
    logic unused_cfg_s;
    assign unused_cfg_s = ^{local_mac_add, local_ip_add, da_s, tpa_s};
`endif

    // Receive FSM; the result is registered on the edge that sees rx_dv fall, so it is
    // visible during CHECK, and CHECK itself ignores any new rx_dv.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r          <= ST_SYNC;
            count_r          <= 11'd0;
            crc_r            <= CRC_INIT;
            drop_from_data_r <= 1'b0;
            arp_valid        <= 1'b0;
            frame_err        <= 1'b0;
            sender_mac_add   <= 48'h0;
            sender_ip_add    <= 32'h0;
            operator         <= 16'h0;
            for (int i = 0; i < 42; i++) begin
                hdr_r[i] <= 8'h00;
            end
        end else begin
            arp_valid <= 1'b0;
            frame_err <= 1'b0;
            case (state_r)
                ST_SYNC: begin
                    if (!gmii_rx_dv) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_SYNC;
                    end
                end
                ST_IDLE, ST_PREAMBLE: begin
                    if (gmii_rx_dv && (gmii_rxd == 8'h55)) begin
                        state_r <= ST_PREAMBLE;
                    end else if (gmii_rx_dv && (gmii_rxd == 8'hD5)) begin
                        state_r <= ST_DATA;
                        count_r <= 11'd0;
                        crc_r   <= CRC_INIT;
                    end else if (gmii_rx_dv || (state_r == ST_PREAMBLE)) begin
                        state_r          <= ST_DROP;
                        drop_from_data_r <= 1'b0;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_DATA: begin
                    if (!gmii_rx_dv) begin
                        state_r <= ST_CHECK;
                        if (frame_good_s) begin
                            arp_valid      <= 1'b1;
                            sender_mac_add <= sha_s;
                            sender_ip_add  <= spa_s;
                            operator       <= oper_s;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else if (gmii_rx_er || (count_r >= MAX_LEN)) begin
                        state_r          <= ST_DROP;
                        drop_from_data_r <= 1'b1;
                    end else begin
                        crc_r   <= crc32_byte(crc_r, gmii_rxd);
                        count_r <= (count_r == 11'h7FF) ? count_r : count_r + 11'd1;
                        if (count_r < HDR_BYTES) begin
                            hdr_r[count_r[5:0]] <= gmii_rxd;
                        end
                    end
                end
                ST_CHECK: begin
                    state_r <= ST_IDLE;
                end
                ST_DROP: begin
                    if (!gmii_rx_dv) begin
                        frame_err <= drop_from_data_r;
                        state_r   <= ST_IDLE;
                    end else begin
                        state_r <= ST_DROP;
                    end
                end
                default: begin
                    state_r <= ST_SYNC;
                end
            endcase
        end
    end

endmodule
